// File: rtl/chess_clock_if.sv
// Chess clock I/O bundle: divider clocks and buttons in, display and speaker
// signals out. The controller takes the slave side.
interface chess_clock_if;
   logic        clk_10;
   logic        clk_763;
   logic        btn_a;
   logic        btn_b;
   logic        btn_pause;
   logic        btn_clr;
   logic [12:0] time_a;
   logic [12:0] time_b;
   logic [1:0]  active;
   logic        timeout_a;
   logic        timeout_b;
   logic        buzzer;

   modport master (
      output clk_10, clk_763, btn_a, btn_b, btn_pause, btn_clr,
      input  time_a, time_b, active, timeout_a, timeout_b, buzzer
   );

   modport slave (
      input  clk_10, clk_763, btn_a, btn_b, btn_pause, btn_clr,
      output time_a, time_b, active, timeout_a, timeout_b, buzzer
   );
endinterface

// File: rtl/chess_clock_ctrl.sv
// Two-player chess clock controller. One 10 Hz tick is shared by two
// countdown counters; a turn FSM picks which one runs, detects the fallen
// flag and gates the buzzer clock onto the speaker.
module chess_clock_ctrl #(
   parameter int INIT_DS  = 6000,
   parameter int CLICK_DS = 1,
   parameter int BEEP_DS  = 20
) (
   input  logic         clk_50m,
   input  logic         rst,
   chess_clock_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      RUN_A,
      RUN_B,
      PAUSE,
      OVER
   } state_t;

   localparam logic [12:0] INIT_V  = 13'(INIT_DS);
   localparam logic [4:0]  CLICK_V = 5'(CLICK_DS);
   localparam logic [4:0]  BEEP_V  = 5'(BEEP_DS);

   // Bit order of the conditioned inputs: {clr, pause, b, a, tick}.
   logic [4:0] raw_in;
   logic [4:0] sync1, sync2, sync_d;
   logic [4:0] pulse;
   logic       tick, pa, pb, pp, pc;

   logic       clk763_q;

   state_t      state, state_nxt;
   logic [12:0] time_a, time_a_nxt;
   logic [12:0] time_b, time_b_nxt;
   logic        timeout_a, timeout_a_nxt;
   logic        timeout_b, timeout_b_nxt;
   logic        resume_b, resume_b_nxt;   // 0 = resume A, 1 = resume B
   logic [4:0]  beep_cnt, beep_cnt_nxt;
   logic        buzzer_q;

   assign raw_in = {bus.btn_clr, bus.btn_pause, bus.btn_b, bus.btn_a, bus.clk_10};
   assign {pc, pp, pb, pa, tick} = pulse;

   // Two-flop synchronizers followed by registered rising-edge detectors.
   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         sync1  <= '0;
         sync2  <= '0;
         sync_d <= '0;
         pulse  <= '0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the previous
         // cycle's value, which is what builds the synchronizer chain.
         sync1  <= raw_in;
         sync2  <= sync1;
         sync_d <= sync2;
         pulse  <= sync2 & ~sync_d;
      end
   end

   // Turn state and the two countdown counters with their flags.
   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         time_a    <= INIT_V;
         time_b    <= INIT_V;
         timeout_a <= 1'b0;
         timeout_b <= 1'b0;
         resume_b  <= 1'b0;
         beep_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         time_a    <= time_a_nxt;
         time_b    <= time_b_nxt;
         timeout_a <= timeout_a_nxt;
         timeout_b <= timeout_b_nxt;
         resume_b  <= resume_b_nxt;
         beep_cnt  <= beep_cnt_nxt;
      end
   end

   // Next-state logic; clear has top priority, then a terminal tick, then
   // pause, then a move.
   always_comb begin
      // NOTE: every output of this block is given a hold value first so no
      // path through the case leaves it unassigned (no latch).
      state_nxt     = state;
      time_a_nxt    = time_a;
      time_b_nxt    = time_b;
      timeout_a_nxt = timeout_a;
      timeout_b_nxt = timeout_b;
      resume_b_nxt  = resume_b;
      beep_cnt_nxt  = (tick && beep_cnt != 5'd0) ? beep_cnt - 5'd1 : beep_cnt;

      if (pc) begin
         state_nxt     = IDLE;
         time_a_nxt    = INIT_V;
         time_b_nxt    = INIT_V;
         timeout_a_nxt = 1'b0;
         timeout_b_nxt = 1'b0;
         beep_cnt_nxt  = '0;
      end else begin
         case (state)
            IDLE: begin
               if (pa) begin
                  state_nxt    = RUN_B;
                  beep_cnt_nxt = CLICK_V;
               end else if (pb) begin
                  state_nxt    = RUN_A;
                  beep_cnt_nxt = CLICK_V;
               end
            end
            RUN_A: begin
               if (tick && time_a <= 13'd1) begin
                  time_a_nxt    = '0;
                  timeout_a_nxt = 1'b1;
                  state_nxt     = OVER;
                  beep_cnt_nxt  = BEEP_V;
               end else begin
                  if (tick) time_a_nxt = time_a - 13'd1;
                  if (pp) begin
                     state_nxt    = PAUSE;
                     resume_b_nxt = 1'b0;
                  end else if (pa) begin
                     state_nxt    = RUN_B;
                     beep_cnt_nxt = CLICK_V;
                  end
               end
            end
            RUN_B: begin
               if (tick && time_b <= 13'd1) begin
                  time_b_nxt    = '0;
                  timeout_b_nxt = 1'b1;
                  state_nxt     = OVER;
                  beep_cnt_nxt  = BEEP_V;
               end else begin
                  if (tick) time_b_nxt = time_b - 13'd1;
                  if (pp) begin
                     state_nxt    = PAUSE;
                     resume_b_nxt = 1'b1;
                  end else if (pb) begin
                     state_nxt    = RUN_A;
                     beep_cnt_nxt = CLICK_V;
                  end
               end
            end
            PAUSE: begin
               if (pp) state_nxt = resume_b ? RUN_B : RUN_A;
            end
            OVER: ;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Registered buzzer gate: divider tone passes while beep_cnt is nonzero.
   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         clk763_q <= 1'b0;
         buzzer_q <= 1'b0;
      end else begin
         clk763_q <= bus.clk_763;
         buzzer_q <= clk763_q & (beep_cnt != 5'd0);
      end
   end

   // Output decode: active side follows the running state.
   always_comb begin
      bus.active = 2'b00;
      if (state == RUN_A) bus.active = 2'b01;
      if (state == RUN_B) bus.active = 2'b10;
   end

   assign bus.time_a    = time_a;
   assign bus.time_b    = time_b;
   assign bus.timeout_a = timeout_a;
   assign bus.timeout_b = timeout_b;
   assign bus.buzzer    = buzzer_q;

endmodule
